// File: rtl/nic_link_allocator_pkg.sv
// Shared definitions for the NIC link allocator: FSM state encoding and the
// rotating first-one (ff1) search used by the round-robin arbiter.
package nic_link_allocator_pkg;

    // Packet-lock FSM encoding
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } la_state_e;

    // The ff1 search works on a fixed maximum width. Narrower request
    // vectors are zero-extended by the caller.
    localparam int unsigned FF1_MAX_N = 32;
    localparam int unsigned FF1_ID_W  = 5;

    typedef struct packed {
        logic                found;
        logic [FF1_ID_W-1:0] id;
    } ff1_t;

    // Rotating first-one search: scans positions start, start+1, ... n-1,
    // 0, ... start-1 and returns the first requesting index.
    // start must already be in range 0..n-1.
    function automatic ff1_t ff1_rot(input logic [FF1_MAX_N-1:0] req,
                                     input int unsigned          n,
                                     input int unsigned          start);
        ff1_t        res;
        int unsigned idx;
        res = '0;
        idx = 0;
        for (int unsigned k = 0; k < FF1_MAX_N; k++) begin
            if ((k < n) && !res.found) begin
                idx = start + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[FF1_ID_W-1:0]]) begin
                    res.found = 1'b1;
                    res.id    = idx[FF1_ID_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nic_link_allocator_rr_priority_select.sv
// Rotating priority select: finds the first requesting buffer at or after
// start_i, wrapping from N_REQ-1 back to 0. Purely combinational.
module rr_priority_select
    import nic_link_allocator_pkg::*;
#(
    parameter int N_REQ  = 6,
    parameter int W_ID   = 3
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [W_ID-1:0]  start_i,
    output logic             found_o,
    output logic [W_ID-1:0]  id_o
);

    logic [FF1_MAX_N-1:0] req_ext;
    ff1_t                 res;
    logic                 unused_id_hi;

    assign req_ext = FF1_MAX_N'(req_i);

    // Run the shared rotating search over the zero-extended request vector
    always_comb begin
        res = ff1_rot(req_ext, N_REQ, 32'(start_i));
    end

    assign found_o      = res.found;
    assign id_o         = W_ID'(res.id);
    assign unused_id_hi = ^res.id;

endmodule

// File: rtl/nic_link_allocator.sv
// NIC link allocator: round-robin arbitration of fifo_out_buffers onto the
// single NIC->NoC output link. Grants are combinational; the granted buffer
// drives its flit on the following cycle.
//
// Optional feature: define NIC_LA_PACKET_LOCK_EN to enable wormhole packet
// lock (the link stays with one buffer from head flit to tail flit). Without
// it every flit is arbitrated independently and lock_o is tied low.
//
// Handshake: a grant (g_la_o=1) is only issued when link_ready_i=1 and an
// eligible request exists; the id output is 0 whenever g_la_o=0.
module nic_link_allocator
    import nic_link_allocator_pkg::*;
#(
    parameter int N_FIFO_OUT_BUFFER      = 6,
    parameter int N_BITS_FIFO_OUT_BUFFER = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_FIFO_OUT_BUFFER-1:0]      r_la_i,
    input  logic [N_FIFO_OUT_BUFFER-1:0]      r_la_tail_i,
    input  logic                              link_ready_i,
    output logic                              g_la_o,
    output logic [N_BITS_FIFO_OUT_BUFFER-1:0] g_la_fifo_out_buffer_id_o,
    output logic                              lock_o
);

    localparam int N = N_FIFO_OUT_BUFFER;
    localparam int W = N_BITS_FIFO_OUT_BUFFER;

    logic [W-1:0] rr_ptr_q;
    logic [W-1:0] rr_ptr_d;
    logic [W-1:0] search_start;
    logic [N-1:0] eligible;
    logic         sel_found;
    logic [W-1:0] sel_id;
    logic         grant;

    // Search begins one past the last winner, wrapping at N-1
    always_comb begin
        if (rr_ptr_q == W'(N - 1)) begin
            search_start = '0;
        end else begin
            search_start = rr_ptr_q + 1'b1;
        end
    end

    rr_priority_select #(
        .N_REQ (N),
        .W_ID  (W)
    ) u_rr_select (
        .req_i   (eligible),
        .start_i (search_start),
        .found_o (sel_found),
        .id_o    (sel_id)
    );

    // No grant while the link is stalled or while reset is held
    assign grant                     = sel_found & link_ready_i & ~rst;
    assign g_la_o                    = grant;
    assign g_la_fifo_out_buffer_id_o = grant ? sel_id : '0;

    // Pointer follows the most recent winner, holds otherwise
    always_comb begin
        rr_ptr_d = grant ? sel_id : rr_ptr_q;
    end

    // Round-robin pointer register; reset value makes buffer 0 searched first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= W'(N - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef NIC_LA_PACKET_LOCK_EN
    la_state_e    state_q;
    logic [W-1:0] lock_id_q;

    // While locked only the owning buffer may compete for the link
    always_comb begin
        if (state_q == LOCKED) begin
            eligible = r_la_i & (N'(1) << lock_id_q);
        end else begin
            eligible = r_la_i;
        end
    end

    // Packet-lock FSM: a non-tail grant locks, a tail grant under lock releases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant && !r_la_tail_i[sel_id]) begin
                        state_q   <= LOCKED;
                        lock_id_q <= sel_id;
                    end
                end
                LOCKED: begin
                    if (grant && r_la_tail_i[sel_id]) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lock_o = (state_q == LOCKED);
`else
    logic unused_tail;

    // Every flit competes on its own; tail markers carry no meaning here
    always_comb begin
        eligible = r_la_i;
    end

    assign unused_tail = ^r_la_tail_i;
    assign lock_o      = 1'b0;
`endif

endmodule

// File: tb/tb_nic_link_allocator.sv
// Testbench for nic_link_allocator (N_FIFO_OUT_BUFFER=6).
// Directed sequences with literal expectations plus a randomized run, all
// cross-checked every cycle against a behavioural model of the arbiter.
module tb_nic_link_allocator;

    localparam int N = 6;
    localparam int W = 3;
`ifdef NIC_LA_PACKET_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] r_la;
    logic [N-1:0] r_la_tail;
    logic         link_ready;
    logic         g_la;
    logic [W-1:0] g_id;
    logic         lock;

    int n_tests;
    int n_fail;

    logic [W-1:0] exp_q[$];

    nic_link_allocator #(
        .N_FIFO_OUT_BUFFER      (N),
        .N_BITS_FIFO_OUT_BUFFER (W)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .r_la_i                    (r_la),
        .r_la_tail_i               (r_la_tail),
        .link_ready_i              (link_ready),
        .g_la_o                    (g_la),
        .g_la_fifo_out_buffer_id_o (g_id),
        .lock_o                    (lock)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // Model state: last winner, whether a packet owns the link, and its owner.
    int m_ptr;
    bit m_locked;
    int m_lock_id;
    int m_win;
    int m_c;
    bit e_g;
    int e_id;
    bit e_lock;

    always @(negedge clk) begin
        if (rst) begin
            m_ptr     = N - 1;
            m_locked  = 1'b0;
            m_lock_id = 0;
            e_g       = 1'b0;
            e_id      = 0;
            e_lock    = 1'b0;
        end else begin
            e_lock = LOCK_EN && m_locked;
            m_win  = -1;
            if (LOCK_EN && m_locked) begin
                if (r_la[m_lock_id]) m_win = m_lock_id;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (m_win < 0 && r_la[m_c]) m_win = m_c;
                end
            end
            e_g  = link_ready && (m_win >= 0);
            e_id = e_g ? m_win : 0;
            if (e_g) begin
                m_ptr = m_win;
                if (LOCK_EN) begin
                    if (!m_locked && !r_la_tail[m_win]) begin
                        m_locked  = 1'b1;
                        m_lock_id = m_win;
                    end else if (m_locked && r_la_tail[m_win]) begin
                        m_locked = 1'b0;
                    end
                end
            end
        end
        n_tests++;
        if (g_la !== e_g || int'(g_id) != e_id || lock !== e_lock) begin
            n_fail++;
            $display("FAIL model t=%0t: got g=%b id=%0d lock=%b, want g=%b id=%0d lock=%b",
                     $time, g_la, g_id, lock, e_g, e_id, e_lock);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] tail, input logic rdy);
        @(posedge clk);
        #1;
        r_la       = req;
        r_la_tail  = tail;
        link_ready = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        r_la       = '1;
        r_la_tail  = '1;
        link_ready = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        r_la = '0;
    endtask

    // Scoreboard check at the falling edge; grant ids come from exp_q
    task automatic check_cycle(input string name, input logic eg, input logic el);
        logic [W-1:0] eid;
        @(negedge clk);
        eid = '0;
        if (eg) begin
            if (exp_q.size() > 0) eid = exp_q.pop_front();
        end
        n_tests++;
        if (g_la !== eg || g_id !== eid || lock !== el) begin
            n_fail++;
            $display("FAIL %s t=%0t: got g=%b id=%0d lock=%b, want g=%b id=%0d lock=%b",
                     name, $time, g_la, g_id, lock, eg, eid, el);
        end
    endtask

    task automatic check_now(input string name, input logic eg, input logic [W-1:0] eid,
                             input logic el);
        n_tests++;
        if (g_la !== eg || g_id !== eid || lock !== el) begin
            n_fail++;
            $display("FAIL %s t=%0t: got g=%b id=%0d lock=%b, want g=%b id=%0d lock=%b",
                     name, $time, g_la, g_id, lock, eg, eid, el);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] tail_v;
        logic [W-1:0] ids30 [6];
        logic         lk30  [6];
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        r_la       = '1;
        r_la_tail  = '1;
        link_ready = 1'b1;

        // Outputs quiet while reset is held even with every buffer requesting
        @(negedge clk);
        check_now("reset_hold", 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        r_la = '0;

        // No requests -> no grant
        step(6'b000000, 6'b111111, 1'b1);
        check_cycle("idle_no_req", 1'b0, 1'b0);

        // Single-flit packets from buffers 0,2,5 rotate in order
        exp_q = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5};
        for (int i = 0; i < 6; i++) begin
            step(6'b100101, 6'b111111, 1'b1);
            check_cycle("rr_rotate", 1'b1, 1'b0);
        end

        // Stalled link: no grant and no pointer movement
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(6'b000110, 6'b111111, 1'b0);
            check_cycle("stall", 1'b0, 1'b0);
        end
        exp_q = '{3'd1, 3'd2};
        for (int i = 0; i < 2; i++) begin
            step(6'b000110, 6'b111111, 1'b1);
            check_cycle("after_stall", 1'b1, 1'b0);
        end

        // Multi-flit packet on buffer 1 against single flits on buffer 3
        do_reset();
        if (LOCK_EN) begin
            ids30 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd1};
            lk30  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        end else begin
            ids30 = '{3'd1, 3'd3, 3'd1, 3'd3, 3'd1, 3'd3};
            lk30  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end
        for (int i = 0; i < 6; i++) begin
            tail_v = (i < 3) ? 6'b001000 : 6'b001010;
            exp_q.push_back(ids30[i]);
            step(6'b001010, tail_v, 1'b1);
            check_cycle("packet_lock", 1'b1, lk30[i]);
        end

        // Reset in the middle of a packet owned by buffer 4
        do_reset();
        exp_q.push_back(3'd4);
        step(6'b010000, 6'b000000, 1'b1);
        check_cycle("lock_b4_head", 1'b1, 1'b0);
        exp_q.push_back(LOCK_EN ? 3'd4 : 3'd0);
        step(6'b010001, 6'b000000, 1'b1);
        check_cycle("lock_b4_body", 1'b1, LOCK_EN);
        @(posedge clk);
        #1;
        n_tests++;
        if (lock !== LOCK_EN) begin
            n_fail++;
            $display("FAIL lock_before_rst: got lock=%b, want %b", lock, LOCK_EN);
        end
        #2;
        rst = 1'b1;
        #1;
        check_now("async_rst", 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.push_back(3'd0);
        check_cycle("after_rst", 1'b1, 1'b0);

        // Randomized traffic with occasional resets, checked by the model
        for (int i = 0; i < 3000; i++) begin
            step(N'($urandom_range(0, (1 << N) - 1)) & N'($urandom_range(0, (1 << N) - 1)),
                 N'($urandom_range(0, (1 << N) - 1)),
                 ($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
